fe_capture_ctrl: RTL



---
 rtl/fe_capture_ctrl_if.sv | 32 +++
 rtl/fe_capture_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fe_capture_ctrl_if.sv
// Control/status bundle between the register block, pattern matcher, capture datapath
// and the capture sequencer.
interface fe_capture_ctrl_if #(
  parameter int unsigned pDELAY_WIDTH = 20
) ();
  logic                    I_arm_req;
  logic                    I_abort;
  logic                    I_trigger_mode;
  logic                    I_pm_match;
  logic [pDELAY_WIDTH-1:0] I_trigger_delay;
  logic                    I_capturing;
  logic                    I_fifo_empty;
  logic                    O_fifo_flush;
  logic                    O_arm;
  logic                    O_capture_enable;
  logic                    O_armed;
  logic                    O_triggered;
  logic                    O_done;
  logic [2:0]              O_state;

  modport master (
    output I_arm_req, I_abort, I_trigger_mode, I_pm_match, I_trigger_delay, I_capturing,
           I_fifo_empty,
    input  O_fifo_flush, O_arm, O_capture_enable, O_armed, O_triggered, O_done, O_state
  );

  modport slave (
    input  I_arm_req, I_abort, I_trigger_mode, I_pm_match, I_trigger_delay, I_capturing,
           I_fifo_empty,
    output O_fifo_flush, O_arm, O_capture_enable, O_armed, O_triggered, O_done, O_state
  );
endinterface

// File: rtl/fe_capture_ctrl.sv
// Front-end capture sequencer: arm/flush, trigger wait, trigger delay, capture enable.
// All outputs are registers decoded from the next state, so they line up with the state.
module fe_capture_ctrl #(
  parameter int unsigned pDELAY_WIDTH  = 20,
  parameter int unsigned pFLUSH_CYCLES = 4
) (
  input logic              fe_clk,
  input logic              reset_i,
  fe_capture_ctrl_if.slave bus_io
);

  localparam int unsigned FlushCntW = $clog2(pFLUSH_CYCLES + 1);
  localparam logic [FlushCntW-1:0] FlushMin = FlushCntW'(pFLUSH_CYCLES);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFlush   = 3'd1,
    StArmed   = 3'd2,
    StDelay   = 3'd3,
    StCapture = 3'd4,
    StDone    = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [FlushCntW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [pDELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic                    grace_q, grace_d;
  logic                    triggered_q, triggered_d;
  logic                    fifo_flush_q, arm_q, cap_en_q, armed_q, done_q;
  logic                    arm_take, trigger;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    triggered_d = triggered_q;
    arm_take    = bus_io.I_arm_req && !bus_io.I_abort;
    trigger     = !bus_io.I_trigger_mode || bus_io.I_pm_match;

    if (bus_io.I_abort) begin
      state_d     = StIdle;
      triggered_d = 1'b0;
    end else if (bus_io.I_arm_req) begin
      state_d     = StFlush;
      triggered_d = 1'b0;
      flush_cnt_d = FlushCntW'(1);
    end else begin
      case (state_q)
        StIdle: ;
        StFlush: begin
          // Counter saturates at the minimum; a slow-draining FIFO just holds us here.
          if (flush_cnt_q >= FlushMin && bus_io.I_fifo_empty) begin
            state_d = StArmed;
          end else if (flush_cnt_q < FlushMin) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        StArmed: begin
          if (trigger) begin
            triggered_d = 1'b1;
            if (bus_io.I_trigger_delay == '0) begin
              state_d = StCapture;
            end else begin
              state_d   = StDelay;
              dly_cnt_d = bus_io.I_trigger_delay;
            end
          end
        end
        StDelay: begin
          if (dly_cnt_q == pDELAY_WIDTH'(1)) begin
            state_d = StCapture;
          end else begin
            dly_cnt_d = dly_cnt_q - 1'b1;
          end
        end
        StCapture: begin
          if (!grace_q && !bus_io.I_capturing) begin
            state_d = StDone;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end

    // First capture cycle ignores I_capturing while the datapath sees the new enable.
    grace_d = (state_d == StCapture) && (state_q != StCapture);
  end

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      flush_cnt_q  <= '0;
      dly_cnt_q    <= '0;
      grace_q      <= 1'b0;
      triggered_q  <= 1'b0;
      fifo_flush_q <= 1'b0;
      arm_q        <= 1'b0;
      cap_en_q     <= 1'b0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      grace_q      <= grace_d;
      triggered_q  <= triggered_d;
      fifo_flush_q <= (state_d == StFlush);
      // Low only on the first flush cycle, so each (re)arm yields one rising edge.
      arm_q        <= (state_d != StIdle) && !arm_take;
      cap_en_q     <= (state_d == StCapture);
      armed_q      <= (state_d == StArmed);
      done_q       <= (state_d == StDone);
    end
  end

  assign bus_io.O_fifo_flush     = fifo_flush_q;
  assign bus_io.O_arm            = arm_q;
  assign bus_io.O_capture_enable = cap_en_q;
  assign bus_io.O_armed          = armed_q;
  assign bus_io.O_triggered      = triggered_q;
  assign bus_io.O_done           = done_q;
  assign bus_io.O_state          = state_q;

endmodule
